// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared types and constants for the SD command serializer
package cmd_pkg;

  localparam int         CMD_WIDTH     = 48;
  localparam int         CRC7_BITS     = 7;
  localparam logic [6:0] CRC7_POLY     = 7'h09;
  localparam int         CRC_FIELD_MSB = 7;
  localparam int         CRC_FIELD_LSB = 1;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

  // One step of the x^7+x^3+1 LFSR, message bit entering at the top.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/crc7_gen.sv
// rtl/crc7_gen.sv - serial CRC7 generator, cleared per frame
module crc7_gen
  import cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc <= 7'h00;
    end else if (clear) begin
      crc <= 7'h00;
    end else if (enable) begin
      crc <= crc7_next(crc, bit_in);
    end
  end

endmodule

// File: rtl/cmd_paralelo_serial.sv
// rtl/cmd_paralelo_serial.sv - parallel-to-serial SD CMD line driver; optional CRC7 insertion under CMD_PARALELO_SERIAL_CRC7_EN
module cmd_paralelo_serial
  import cmd_pkg::*;
#(
  parameter int WIDTH    = CMD_WIDTH,
  parameter int CRC_BITS = CRC7_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  if (CRC_BITS != CRC_FIELD_MSB - CRC_FIELD_LSB + 1) begin : g_crc_bits_check
    $error("CRC_BITS does not match the CRC field position");
  end

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             shifting;
  logic             data_bit;
  logic             tx_bit;

  assign accept   = (state == IDLE) && load && enable;
  assign shifting = (state == SHIFT) && enable;
  assign data_bit = shreg[WIDTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '1;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= data_in;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (enable) begin
            shreg <= {shreg[WIDTH-2:0], 1'b1};
            if (cnt == LAST) begin
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CMD_PARALELO_SERIAL_CRC7_EN
  // Frame bit k is on the line while cnt == WIDTH-1-k, so the CRC window is
  // cnt in [WIDTH-1-CRC_FIELD_MSB, WIDTH-1-CRC_FIELD_LSB].
  localparam logic [CNT_W-1:0] CRC_START = CNT_W'(WIDTH - 1 - CRC_FIELD_MSB);
  localparam logic [CNT_W-1:0] CRC_END   = CNT_W'(WIDTH - 1 - CRC_FIELD_LSB);

  logic [6:0] crc;
  logic       crc_en;
  logic       crc_window;
  logic [2:0] crc_sel;

  assign crc_en     = shifting && (cnt < CRC_START);
  assign crc_window = (cnt >= CRC_START) && (cnt <= CRC_END);
  assign crc_sel    = 3'(CRC_END - cnt);

  crc7_gen u_crc7_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (crc_en),
    .bit_in (data_bit),
    .crc    (crc)
  );

  always_comb begin
    tx_bit = data_bit;
    if (crc_window) begin
      tx_bit = crc[crc_sel];
    end else if (cnt == LAST) begin
      tx_bit = 1'b1;
    end
  end
`else
  assign tx_bit = data_bit;
`endif

  assign serial_out = (state == SHIFT) ? tx_bit : 1'b1;
  assign ready      = (state == IDLE);
  assign busy       = (state == SHIFT);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_cmd_paralelo_serial.sv
// tb/tb_cmd_paralelo_serial.sv - scoreboard bench for cmd_paralelo_serial
module tb_cmd_paralelo_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [47:0] data_in;
  logic        ready;
  logic        serial_out;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  cmd_paralelo_serial dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .data_in    (data_in),
    .ready      (ready),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] tx_frame(input logic [47:0] d);
`ifdef CMD_PARALELO_SERIAL_CRC7_EN
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 47; i >= 8; i--) begin
      fb = d[i] ^ c[6];
      c  = c << 1;
      if (fb) c = c ^ 7'b000_1001;
    end
    return {d[47:8], c, 1'b1};
`else
    return d;
`endif
  endfunction

  task automatic push_frame(input logic [47:0] d);
    logic [47:0] f;
    f = tx_frame(d);
    for (int i = 47; i >= 0; i--) exp_q.push_back(f[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line monitor: hold a bit while stalled, consume it when the next edge shifts.
  always @(negedge clk) begin
    if (busy) begin
      if (exp_q.size() == 0) begin
        check("queue_underrun", 64'(exp_q.size()), 64'd1);
      end else begin
        check("bit", serial_out, exp_q[0]);
        if (enable) void'(exp_q.pop_front());
      end
    end else begin
      check("idle_line", serial_out, 1'b1);
    end
    if (done) done_cnt++;
  end

  task automatic run_frame(input logic [47:0] d, input int stall_at, input int stall_len,
                           input int busy_load_at);
    int shown, cyc, stall_left, d0;
    d0 = done_cnt;
    push_frame(d);
    load = 1'b1; data_in = d; enable = 1'b1;
    step();
    load = 1'b0; data_in = 48'($urandom) << 16;
    cyc = 1; shown = 0; stall_left = stall_len;
    while (!done && cyc < 200) begin
      load = (shown == busy_load_at);
      if (load) data_in = '1;
      enable = !(shown == stall_at && stall_left > 0);
      if (!enable) stall_left--;
      step();
      cyc++;
      if (enable) shown++;
    end
    load = 1'b0; enable = 1'b1;
    check("done_cycle", 64'(cyc), 64'(49 + stall_len));
    check("busy_in_done", busy, 1'b0);
    check("ready_in_done", ready, 1'b0);
    step();
    check("ready_after_done", ready, 1'b1);
    check("done_one_cycle", done, 1'b0);
    repeat (3) step();
    check("no_restart", busy, 1'b0);
    check("bits_left", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int cyc, d0;
    reset = 1'b0; enable = 1'b0; load = 1'b0; data_in = '0;
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_line", serial_out, 1'b1);
    step(); step();
    reset = 1'b1;
    step();

    // Load without enable is ignored in IDLE.
    load = 1'b1; data_in = 48'h0; enable = 1'b0;
    repeat (3) step();
    check("noen_ready", ready, 1'b1);
    check("noen_busy", busy, 1'b0);
    load = 1'b0; enable = 1'b1;
    step();

    run_frame(48'h400000000095, -1, 0, -1);
    run_frame(48'h48000001AA00, -1, 0, -1);
    run_frame(48'h400000000000, -1, 0, -1);
    run_frame(48'h5A3C_0F12_E7B1, 10, 5, -1);
    run_frame(48'h7123_4567_89AB, -1, 0, 20);

    // Reset mid-frame at bit 30.
    d0 = done_cnt;
    push_frame(48'h4F00_DEAD_BEEF);
    load = 1'b1; data_in = 48'h4F00_DEAD_BEEF; enable = 1'b1;
    step();
    load = 1'b0;
    repeat (30) step();
    check("pre_reset_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort_line", serial_out, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", ready, 1'b1);
    check("abort_done", done, 1'b0);
    exp_q.delete();
    step();
    reset = 1'b1;
    repeat (3) step();
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_frame(48'h4A5A_0000_1234, -1, 0, -1);

    // Back-to-back frames with load held high.
    d0 = done_cnt;
    push_frame(48'h4111_2222_3333);
    push_frame(48'h7EDC_BA98_7654);
    load = 1'b1; data_in = 48'h4111_2222_3333; enable = 1'b1;
    step();
    data_in = 48'h7EDC_BA98_7654;
    cyc = 1;
    while (!done && cyc < 200) begin step(); cyc++; end
    check("b2b_done1", 64'(cyc), 64'd49);
    step();
    check("b2b_idle_gap", ready, 1'b1);
    step();
    check("b2b_start2", busy, 1'b1);
    load = 1'b0;
    cyc = 51;
    while (!done && cyc < 300) begin step(); cyc++; end
    check("b2b_done2", 64'(cyc), 64'd99);
    step();
    check("b2b_bits_left", 64'(exp_q.size()), 64'd0);
    check("b2b_done_count", 64'(done_cnt - d0), 64'd2);

    for (int k = 0; k < 2; k++) run_frame({$urandom, 16'($urandom)}, -1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
